// File: rtl/freq_hop_pkg.sv
// Shared constants and read-FSM encoding for the frequency-hop
// ping-pong RAM sequencer.
package freq_hop_pkg;

    localparam int WORDS_PER_BANK = 128;
    localparam int BYTES_PER_BANK = 4 * WORDS_PER_BANK;
    localparam int WR_BANK_BIT    = $clog2(WORDS_PER_BANK);
    localparam int RD_BANK_BIT    = $clog2(BYTES_PER_BANK);

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_RUN   = 2'd1,
        RD_SWAP  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/freq_hop_fill_ctrl.sv
// Fill-side pointer: write bank, word counter, per-bank full flags
// and the stall / move-to-freed-bank rule.
module freq_hop_fill_ctrl #(
    parameter int WORDS_PER_BANK = 128
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clr_i,
    input  logic                                wr_en_i,
    input  logic                                rel_i,
    input  logic                                rel_bank_i,
    output logic                                wr_ready_o,
    output logic                                wr_acc_o,
    output logic                                wr_bank_o,
    output logic [freq_hop_pkg::WR_BANK_BIT-1:0] wr_cnt_o,
    output logic [1:0]                          bank_full_o
);
    import freq_hop_pkg::*;

    localparam logic [WR_BANK_BIT-1:0] LAST = WR_BANK_BIT'(WORDS_PER_BANK - 1);

    logic                   wr_bank_q, wr_bank_d;
    logic [WR_BANK_BIT-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]             full_q, full_d;
    logic                   own_full;
    logic                   other_full;

    assign own_full   = full_q[wr_bank_q];
    assign other_full = full_q[~wr_bank_q];
    assign wr_ready_o = !own_full;
    assign wr_acc_o   = wr_en_i && !own_full;

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        full_d    = full_q;
        if (wr_acc_o) begin
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_cnt_d          = '0;
                if (!other_full) begin
                    wr_bank_d = ~wr_bank_q;
                end
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end else if (own_full && !other_full) begin
            // stalled writer follows the bank the reader just freed
            wr_bank_d = ~wr_bank_q;
        end
        if (rel_i) begin
            full_d[rel_bank_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
        end else if (clr_i) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
        end
    end

    assign wr_bank_o   = wr_bank_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign bank_full_o = full_q;

endmodule

// File: rtl/freq_hop_pingpong_ctrl.sv
// Ping-pong frequency-hop RAM sequencer: DSP fill side, hop-code drain
// side with valid pipeline, bank swapping and sticky error flags.
module freq_hop_pingpong_ctrl #(
    parameter int WORDS_PER_BANK = freq_hop_pkg::WORDS_PER_BANK,
    parameter int RAM_RD_LAT     = 1
) (
    input  logic        clk_200M_in,
    input  logic        rst_n_in,
    input  logic        sync_clr,
    input  logic        dsp_wr_en,
    input  logic [31:0] dsp_wr_data,
    output logic        dsp_wr_ready,
    input  logic        hop_req,
    output logic [7:0]  hop_freq_out,
    output logic        hop_freq_valid,
    output logic        ram_wea,
    output logic [7:0]  ram_addra,
    output logic [31:0] ram_dina,
    output logic [9:0]  ram_addrb,
    input  logic [7:0]  ram_doutb,
    output logic [1:0]  bank_full,
    output logic        overflow_err,
    output logic        underflow_err
);
    import freq_hop_pkg::*;

    localparam int VLD_W = RAM_RD_LAT + 1;

    logic                   wr_acc;
    logic                   wr_bank;
    logic [WR_BANK_BIT-1:0] wr_cnt;
    logic [1:0]             full;
    logic                   rd_acc;
    logic                   rd_rel;

    rd_state_e              rd_state_q;
    logic                   rd_bank_q;
    logic [RD_BANK_BIT-1:0] rd_cnt_q;
    logic [9:0]             addrb_q;
    logic [VLD_W-1:0]       vld_q;
    logic                   hop_vld_q;
    logic [7:0]             hop_q;
    logic                   wea_q;
    logic [7:0]             addra_q;
    logic [31:0]            dina_q;
    logic                   ovf_q;
    logic                   unf_q;

    assign rd_acc = hop_req && (rd_state_q == RD_RUN);
    assign rd_rel = rd_acc && (rd_cnt_q == '1);

    freq_hop_fill_ctrl #(
        .WORDS_PER_BANK(WORDS_PER_BANK)
    ) u_fill (
        .clk_i       (clk_200M_in),
        .rst_ni      (rst_n_in),
        .clr_i       (sync_clr),
        .wr_en_i     (dsp_wr_en),
        .rel_i       (rd_rel),
        .rel_bank_i  (rd_bank_q),
        .wr_ready_o  (dsp_wr_ready),
        .wr_acc_o    (wr_acc),
        .wr_bank_o   (wr_bank),
        .wr_cnt_o    (wr_cnt),
        .bank_full_o (full)
    );

    always_ff @(posedge clk_200M_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_state_q <= RD_EMPTY;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            addrb_q    <= '0;
            vld_q      <= '0;
            hop_vld_q  <= 1'b0;
            hop_q      <= '0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (sync_clr) begin
            rd_state_q <= RD_EMPTY;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            addrb_q    <= '0;
            vld_q      <= '0;
            hop_vld_q  <= 1'b0;
            hop_q      <= '0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            unique case (rd_state_q)
                RD_EMPTY: begin
                    if (full[rd_bank_q]) begin
                        rd_state_q <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (rd_acc) begin
                        addrb_q  <= {rd_bank_q, rd_cnt_q};
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        if (rd_rel) begin
                            rd_bank_q  <= ~rd_bank_q;
                            rd_state_q <= RD_SWAP;
                        end
                    end
                end
                RD_SWAP: begin
                    rd_state_q <= full[rd_bank_q] ? RD_RUN : RD_EMPTY;
                end
                default: rd_state_q <= RD_EMPTY;
            endcase

            // the last stage lines up with ram_doutb for the oldest request
            vld_q     <= (vld_q << 1) | VLD_W'(rd_acc);
            hop_vld_q <= vld_q[VLD_W-1];
            if (vld_q[VLD_W-1]) begin
                hop_q <= ram_doutb;
            end

            wea_q <= wr_acc;
            if (wr_acc) begin
                addra_q <= {wr_bank, wr_cnt};
                dina_q  <= dsp_wr_data;
            end

            if (dsp_wr_en && !dsp_wr_ready) begin
                ovf_q <= 1'b1;
            end
            if (hop_req && (rd_state_q != RD_RUN)) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign hop_freq_out   = hop_q;
    assign hop_freq_valid = hop_vld_q;
    assign ram_wea        = wea_q;
    assign ram_addra      = addra_q;
    assign ram_dina       = dina_q;
    assign ram_addrb      = addrb_q;
    assign bank_full      = full;
    assign overflow_err   = ovf_q;
    assign underflow_err  = unf_q;

endmodule
